// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: bundles the requester handshake, response handshake and
// FPU control/data signals shared between fpu_arbiter and its environment.
// master: the arbiter side. slave: requesters plus the attached FPU.
interface fpu_arbiter_if #(
    parameter int PRECISION = 32,
    parameter int NUM_REQ   = 2
);
    // Requester side
    logic [NUM_REQ-1:0]           Req_Valid;
    logic [NUM_REQ-1:0]           Req_Ready;
    logic [NUM_REQ*PRECISION-1:0] Req_A;
    logic [NUM_REQ*PRECISION-1:0] Req_B;
    logic [NUM_REQ*2-1:0]         Req_Op;

    // Response side
    logic [NUM_REQ-1:0]           Rsp_Valid;
    logic [NUM_REQ-1:0]           Rsp_Ready;
    logic [PRECISION-1:0]         Rsp_Result;
    logic                         Rsp_Error;

    // FPU side
    logic [PRECISION-1:0]         Fpu_A;
    logic [PRECISION-1:0]         Fpu_B;
    logic [1:0]                   Fpu_Op;
    logic                         Fpu_Start;
    logic [PRECISION-1:0]         Fpu_Result;
    logic                         Fpu_Done;

    modport master (
        input  Req_Valid, Req_A, Req_B, Req_Op, Rsp_Ready, Fpu_Result, Fpu_Done,
        output Req_Ready, Rsp_Valid, Rsp_Result, Rsp_Error,
               Fpu_A, Fpu_B, Fpu_Op, Fpu_Start
    );

    modport slave (
        output Req_Valid, Req_A, Req_B, Req_Op, Rsp_Ready, Fpu_Result, Fpu_Done,
        input  Req_Ready, Rsp_Valid, Rsp_Result, Rsp_Error,
               Fpu_A, Fpu_B, Fpu_Op, Fpu_Start
    );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter and sequencer sharing one FPU between
// NUM_REQ requesters. Flow per transaction: IDLE (grant + capture) ->
// LAUNCH (Fpu_Start held START_CYCLES) -> WAIT (for Fpu_Done) -> RESPOND.
// Optional WAIT watchdog compiled in with macro FPU_ARB_TIMEOUT_EN; without
// it Rsp_Error is tied low and WAIT lasts until Fpu_Done.
module fpu_arbiter #(
    parameter int PRECISION      = 32,
    parameter int NUM_REQ        = 2,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic           Clk,
    input  logic           Reset,
    fpu_arbiter_if.master  bus
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int START_W = $clog2(START_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [IDX_W-1:0]     last_reg, last_next;
    logic [START_W-1:0]   start_cnt_reg, start_cnt_next;
    logic [PRECISION-1:0] fpu_a_reg, fpu_a_next;
    logic [PRECISION-1:0] fpu_b_reg, fpu_b_next;
    logic [1:0]           fpu_op_reg, fpu_op_next;
    logic [PRECISION-1:0] result_reg, result_next;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Quiet NaN with every exponent and mantissa bit set, sign clear.
    localparam logic [PRECISION-1:0] NAN_VALUE = {1'b0, {(PRECISION-1){1'b1}}};
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic                 error_reg, error_next;
`endif

    // Rotated view of the request vector starting at last+1, so the lowest
    // rotated position that is valid is the round-robin winner.
    logic [IDX_W-1:0]     rot_idx   [NUM_REQ];
    logic [NUM_REQ-1:0]   rot_valid;
    logic [PRECISION-1:0] req_a_slice [NUM_REQ];
    logic [PRECISION-1:0] req_b_slice [NUM_REQ];
    logic [1:0]           req_op_slice [NUM_REQ];
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_found;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot_idx[gi]   = IDX_W'((32'(last_reg) + gi + 1) % NUM_REQ);
            assign rot_valid[gi] = bus.Req_Valid[rot_idx[gi]];
        end
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_a_slice[gi]  = bus.Req_A[gi*PRECISION +: PRECISION];
            assign req_b_slice[gi]  = bus.Req_B[gi*PRECISION +: PRECISION];
            assign req_op_slice[gi] = bus.Req_Op[gi*2 +: 2];
        end
    endgenerate

    // Priority pick over the rotated vector: scan downward so the lowest
    // valid rotated position is the one that sticks.
    always_comb begin
        grant_idx   = '0;
        grant_found = |rot_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_idx = rot_idx[k];
            end
        end
    end

    // Handshake decode: ready only for the winner while IDLE, response valid
    // only for the owner while RESPOND.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_reg == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_reg == RESPOND) begin
            rsp_valid[owner_reg] = 1'b1;
        end
    end

    // Next-state and datapath-update logic for the sequencing FSM.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        start_cnt_next = start_cnt_reg;
        fpu_a_next     = fpu_a_reg;
        fpu_b_next     = fpu_b_reg;
        fpu_op_next    = fpu_op_reg;
        result_next    = result_reg;
`ifdef FPU_ARB_TIMEOUT_EN
        wait_cnt_next  = wait_cnt_reg;
        error_next     = error_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    fpu_a_next     = req_a_slice[grant_idx];
                    fpu_b_next     = req_b_slice[grant_idx];
                    fpu_op_next    = req_op_slice[grant_idx];
                    owner_next     = grant_idx;
                    start_cnt_next = '0;
                    state_next     = LAUNCH;
                end
            end
            LAUNCH: begin
                // Fpu_Done is deliberately ignored here: the FPU is held in
                // reset and its Done may still reflect the previous operation.
                if (start_cnt_reg == START_W'(START_CYCLES - 1)) begin
                    state_next    = WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                    wait_cnt_next = '0;
`endif
                end else begin
                    start_cnt_next = start_cnt_reg + 1'b1;
                end
            end
            WAIT: begin
                if (bus.Fpu_Done) begin
                    result_next = bus.Fpu_Result;
                    state_next  = RESPOND;
`ifdef FPU_ARB_TIMEOUT_EN
                    error_next  = 1'b0;
                end else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_next = NAN_VALUE;
                    error_next  = 1'b1;
                    state_next  = RESPOND;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
`endif
                end
            end
            RESPOND: begin
                if (bus.Rsp_Ready[owner_reg]) begin
                    last_next  = owner_reg;
                    state_next = IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
                    error_next = 1'b0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            last_reg      <= IDX_W'(NUM_REQ - 1);
            start_cnt_reg <= '0;
            fpu_a_reg     <= '0;
            fpu_b_reg     <= '0;
            fpu_op_reg    <= '0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            start_cnt_reg <= start_cnt_next;
            fpu_a_reg     <= fpu_a_next;
            fpu_b_reg     <= fpu_b_next;
            fpu_op_reg    <= fpu_op_next;
            result_reg    <= result_next;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog counter and error flag registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            error_reg    <= error_next;
        end
    end
    assign bus.Rsp_Error = error_reg;
`else
    assign bus.Rsp_Error = 1'b0;
`endif

    assign bus.Req_Ready  = req_ready;
    assign bus.Rsp_Valid  = rsp_valid;
    assign bus.Rsp_Result = result_reg;
    assign bus.Fpu_A      = fpu_a_reg;
    assign bus.Fpu_B      = fpu_b_reg;
    assign bus.Fpu_Op     = fpu_op_reg;
    assign bus.Fpu_Start  = (state_reg == LAUNCH);

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed self-checking bench for fpu_arbiter with a small
// behavioural FPU model whose results come from a hand-computed table.
module tb_fpu_arbiter;
    localparam int P = 32;
    localparam int N = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fpu_arbiter_if #(.PRECISION(P), .NUM_REQ(N)) bus ();

    fpu_arbiter #(
        .PRECISION(P), .NUM_REQ(N), .START_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    // ---------------- FPU model ----------------
    logic        done_reg;
    logic [31:0] res_reg;
    int          lat_cnt;
    bit          hang = 1'b0;
    bit          stale_hold = 1'b0;

    function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
        if (a == 32'h3FC00000 && b == 32'h3FC00000 && op == 2'd2) return 32'h40100000;
        if (a == 32'h40A00000 && b == 32'h40000000 && op == 2'd0) return 32'h40E00000;
        if (a == 32'h40A00000 && b == 32'h40000000 && op == 2'd1) return 32'h40400000;
        if (a == 32'h42C80000 && b == 32'h42480000 && op == 2'd3) return 32'h40000000;
        return 32'hDEADBEEF;
    endfunction

    // Done rises four cycles after the start pulse ends and stays high until
    // the next start, so it is stale when the next launch begins.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lat_cnt  <= 0;
            done_reg <= 1'b0;
            res_reg  <= '0;
        end else if (bus.Fpu_Start) begin
            lat_cnt  <= 0;
            done_reg <= 1'b0;
        end else if (lat_cnt < 3) begin
            lat_cnt <= lat_cnt + 1;
        end else if (lat_cnt == 3) begin
            lat_cnt  <= 4;
            done_reg <= !hang;
            res_reg  <= calc(bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op);
        end
    end
    assign bus.Fpu_Done   = done_reg | (stale_hold & bus.Fpu_Start);
    assign bus.Fpu_Result = res_reg;

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        bus.Req_A[r*32 +: 32] = a;
        bus.Req_B[r*32 +: 32] = b;
        bus.Req_Op[r*2 +: 2]  = op;
        bus.Req_Valid[r]      = 1'b1;
    endtask

    // Runs one transaction from grant to response handshake (no comparisons).
    task automatic serve_one(output logic [N-1:0] granted, output logic [N-1:0] rsp_v,
                             output logic [31:0] res, output logic err, output bit ok);
        int n;
        ok = 1'b1; granted = '0; rsp_v = '0; res = '0; err = 1'b0;
        #1;
        n = 0;
        while (bus.Req_Ready == '0 && n < 50) begin @(negedge Clk); #1; n++; end
        if (bus.Req_Ready == '0) begin ok = 1'b0; return; end
        granted = bus.Req_Ready;
        @(negedge Clk);
        bus.Req_Valid = bus.Req_Valid & ~granted;
        n = 0;
        while (bus.Rsp_Valid == '0 && n < 100) begin @(negedge Clk); n++; end
        if (bus.Rsp_Valid == '0) begin ok = 1'b0; return; end
        rsp_v = bus.Rsp_Valid;
        res   = bus.Rsp_Result;
        err   = bus.Rsp_Error;
        $display("txn: grant=%b rsp_valid=%b result=%h error=%b", granted, rsp_v, res, err);
        bus.Rsp_Ready = rsp_v;
        @(negedge Clk);
        bus.Rsp_Ready = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({bus.Req_Ready, bus.Rsp_Valid} !== '0) begin
            errors++; $display("FAIL reset_handshake: got %b, expected 0", {bus.Req_Ready, bus.Rsp_Valid});
        end
        checks++;
        if ({bus.Rsp_Result, bus.Rsp_Error} !== '0) begin
            errors++; $display("FAIL reset_response: got %h, expected 0", {bus.Rsp_Result, bus.Rsp_Error});
        end
        checks++;
        if ({bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op, bus.Fpu_Start} !== '0) begin
            errors++; $display("FAIL reset_fpu: got %h, expected 0", {bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op, bus.Fpu_Start});
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.Req_Ready !== 2'b00) begin
            errors++; $display("FAIL idle_no_req_ready: got %b, expected 00", bus.Req_Ready);
        end
    endtask

    task automatic test_single_mul();
        int cnt;
        set_req(0, 32'h3FC00000, 32'h3FC00000, 2'd2);
        #1;
        checks++;
        if (bus.Req_Ready !== 2'b01) begin
            errors++; $display("FAIL mul_grant: got %b, expected 01", bus.Req_Ready);
        end
        @(negedge Clk);
        bus.Req_Valid[0] = 1'b0;
        checks++;
        if ({bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op} !== {32'h3FC00000, 32'h3FC00000, 2'd2}) begin
            errors++; $display("FAIL mul_capture: got %h %h %h, expected 3fc00000 3fc00000 2",
                               bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op);
        end
        checks++;
        if (bus.Req_Ready !== 2'b00) begin
            errors++; $display("FAIL mul_ready_in_launch: got %b, expected 00", bus.Req_Ready);
        end
        cnt = 0;
        while (bus.Fpu_Start === 1'b1 && cnt < 10) begin cnt++; @(negedge Clk); end
        checks++;
        if (cnt != 2) begin
            errors++; $display("FAIL mul_start_cycles: got %0d, expected 2", cnt);
        end
        cnt = 0;
        while (bus.Fpu_Done !== 1'b1 && cnt < 50) begin cnt++; @(negedge Clk); end
        checks++;
        if (bus.Fpu_Done !== 1'b1) begin
            errors++; $display("FAIL mul_done_wait: got timeout, expected Fpu_Done");
        end
        checks++;
        if (bus.Rsp_Valid !== 2'b00) begin
            errors++; $display("FAIL mul_rsp_before_done_edge: got %b, expected 00", bus.Rsp_Valid);
        end
        @(negedge Clk);
        checks++;
        if ({bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Error} !== {2'b01, 32'h40100000, 1'b0}) begin
            errors++; $display("FAIL mul_response: got %b %h %b, expected 01 40100000 0",
                               bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Error);
        end
        $display("txn: grant=01 rsp_valid=%b result=%h error=%b", bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Error);
        bus.Rsp_Ready = 2'b01;
        @(negedge Clk);
        bus.Rsp_Ready = 2'b00;
        checks++;
        if (bus.Rsp_Valid !== 2'b00) begin
            errors++; $display("FAIL mul_rsp_clear: got %b, expected 00", bus.Rsp_Valid);
        end
    endtask

    task automatic test_fair_pair();
        logic [N-1:0] g, v;
        logic [31:0]  r;
        logic         e;
        bit           ok;
        logic [N-1:0] exp_g [2];
        logic [31:0]  exp_r [2];
        exp_g[0] = 2'b01; exp_r[0] = 32'h40E00000;
        exp_g[1] = 2'b10; exp_r[1] = 32'h40000000;
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        for (int round = 0; round < 2; round++) begin
            set_req(0, 32'h40A00000, 32'h40000000, 2'd0);
            set_req(1, 32'h42C80000, 32'h42480000, 2'd3);
            for (int t = 0; t < 2; t++) begin
                serve_one(g, v, r, e, ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL pair_timeout r%0d t%0d: got no handshake, expected one", round, t);
                end
                checks++;
                if ({g, v, r, e} !== {exp_g[t], exp_g[t], exp_r[t], 1'b0}) begin
                    errors++; $display("FAIL pair_order r%0d t%0d: got %b %b %h %b, expected %b %b %h 0",
                                       round, t, g, v, r, e, exp_g[t], exp_g[t], exp_r[t]);
                end
            end
        end
    endtask

    task automatic test_rsp_hold();
        logic [N-1:0] g, v;
        logic [31:0]  r;
        logic         e;
        bit           ok;
        int           n;
        set_req(0, 32'h40A00000, 32'h40000000, 2'd1);
        set_req(1, 32'h40A00000, 32'h40000000, 2'd0);
        #1;
        checks++;
        if (bus.Req_Ready !== 2'b01) begin
            errors++; $display("FAIL hold_grant: got %b, expected 01", bus.Req_Ready);
        end
        @(negedge Clk);
        bus.Req_Valid[0] = 1'b0;
        n = 0;
        while (bus.Rsp_Valid == '0 && n < 100) begin @(negedge Clk); n++; end
        bus.Rsp_Ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.Rsp_Valid, bus.Rsp_Result, bus.Req_Ready} !== {2'b01, 32'h40400000, 2'b00}) begin
                errors++; $display("FAIL hold_cycle%0d: got %b %h %b, expected 01 40400000 00",
                                   i, bus.Rsp_Valid, bus.Rsp_Result, bus.Req_Ready);
            end
            @(negedge Clk);
        end
        $display("txn: grant=01 rsp_valid=%b result=%h error=%b", bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Error);
        bus.Rsp_Ready = 2'b01;
        @(negedge Clk);
        bus.Rsp_Ready = 2'b00;
        #1;
        checks++;
        if (bus.Req_Ready !== 2'b10) begin
            errors++; $display("FAIL hold_turnaround: got %b, expected 10", bus.Req_Ready);
        end
        serve_one(g, v, r, e, ok);
        checks++;
        if (!ok || {g, v, r} !== {2'b10, 2'b10, 32'h40E00000}) begin
            errors++; $display("FAIL hold_next: got ok=%0d %b %b %h, expected 10 10 40e00000", ok, g, v, r);
        end
    endtask

    task automatic test_stale_done();
        logic [N-1:0] g, v;
        logic [31:0]  r;
        logic         e;
        bit           ok;
        stale_hold = 1'b1;
        set_req(0, 32'h3FC00000, 32'h3FC00000, 2'd2);
        serve_one(g, v, r, e, ok);
        stale_hold = 1'b0;
        checks++;
        if (!ok || {g, v, r} !== {2'b01, 2'b01, 32'h40100000}) begin
            errors++; $display("FAIL stale_done: got ok=%0d %b %b %h, expected 01 01 40100000", ok, g, v, r);
        end
    endtask

    task automatic test_reset_midop();
        logic [N-1:0] g, v;
        logic [31:0]  r;
        logic         e;
        bit           ok;
        int           n;
        bit           seen;
        set_req(1, 32'h42C80000, 32'h42480000, 2'd3);
        #1;
        checks++;
        if (bus.Req_Ready !== 2'b10) begin
            errors++; $display("FAIL midop_grant: got %b, expected 10", bus.Req_Ready);
        end
        @(negedge Clk);
        bus.Req_Valid[1] = 1'b0;
        n = 0;
        while (bus.Fpu_Start === 1'b1 && n < 10) begin @(negedge Clk); n++; end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.Req_Ready, bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Error,
             bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op, bus.Fpu_Start} !== '0) begin
            errors++; $display("FAIL midop_async_reset: got %b %b %h %b %h %h %h %b, expected all 0",
                               bus.Req_Ready, bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Error,
                               bus.Fpu_A, bus.Fpu_B, bus.Fpu_Op, bus.Fpu_Start);
        end
        @(negedge Clk);
        Reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.Rsp_Valid != '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midop_no_response: got response, expected none");
        end
        set_req(0, 32'h40A00000, 32'h40000000, 2'd0);
        set_req(1, 32'h42C80000, 32'h42480000, 2'd3);
        serve_one(g, v, r, e, ok);
        checks++;
        if (!ok || {g, v, r} !== {2'b01, 2'b01, 32'h40E00000}) begin
            errors++; $display("FAIL midop_priority: got ok=%0d %b %b %h, expected 01 01 40e00000", ok, g, v, r);
        end
        serve_one(g, v, r, e, ok);
        checks++;
        if (!ok || {g, v, r} !== {2'b10, 2'b10, 32'h40000000}) begin
            errors++; $display("FAIL midop_second: got ok=%0d %b %b %h, expected 10 10 40000000", ok, g, v, r);
        end
    endtask

`ifdef FPU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N-1:0] g, v;
        logic [31:0]  r;
        logic         e;
        bit           ok;
        hang = 1'b1;
        set_req(0, 32'h40A00000, 32'h40000000, 2'd0);
        serve_one(g, v, r, e, ok);
        hang = 1'b0;
        checks++;
        if (!ok || {g, v, r, e} !== {2'b01, 2'b01, 32'h7FFFFFFF, 1'b1}) begin
            errors++; $display("FAIL timeout_nan: got ok=%0d %b %b %h %b, expected 01 01 7fffffff 1", ok, g, v, r, e);
        end
        checks++;
        if (bus.Rsp_Error !== 1'b0) begin
            errors++; $display("FAIL timeout_error_clear: got %b, expected 0", bus.Rsp_Error);
        end
        set_req(1, 32'h42C80000, 32'h42480000, 2'd3);
        serve_one(g, v, r, e, ok);
        checks++;
        if (!ok || {g, v, r, e} !== {2'b10, 2'b10, 32'h40000000, 1'b0}) begin
            errors++; $display("FAIL timeout_recover: got ok=%0d %b %b %h %b, expected 10 10 40000000 0", ok, g, v, r, e);
        end
    endtask
`endif

    initial begin
        bus.Req_Valid = '0;
        bus.Req_A     = '0;
        bus.Req_B     = '0;
        bus.Req_Op    = '0;
        bus.Rsp_Ready = '0;
        test_reset();
        test_single_mul();
        test_fair_pair();
        test_rsp_hold();
        test_stale_done();
        test_reset_midop();
`ifdef FPU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: got no completion, expected $finish");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Sequencing controller and round-robin arbiter that shares one `FPU` instance between `NUM_REQ` independent requesters. It accepts operand/opcode requests over a valid/ready handshake and launches the FPU with a start pulse on the FPU's `Reset` input. It waits for `Done`, then returns the registered result to the owning requester over a response handshake. It sits directly in front of `FPU` in the datapath and is the only block that drives the FPU's operand, opcode and start inputs.

## Interface
- `PRECISION`, 32, operand/result width; 32 or 64, matching the attached `FPU`.
- `NUM_REQ`, 2, number of requesters, 2..8.
- `START_CYCLES`, 2, clock cycles `Fpu_Start` is held high per launch; minimum 1.
- `TIMEOUT_CYCLES`, 4095, watchdog limit in WAIT; used only with the configuration macro.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Req_Valid`  in  NUM_REQ  per-requester request valid.
- `Req_Ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `Req_A`  in  NUM_REQ*PRECISION  operand A, slice i belongs to requester i.
- `Req_B`  in  NUM_REQ*PRECISION  operand B, slice i.
- `Req_Op`  in  NUM_REQ*2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `Rsp_Valid`  out  NUM_REQ  one-hot response valid for the owning requester.
- `Rsp_Ready`  in  NUM_REQ  per-requester response accept.
- `Rsp_Result`  out  PRECISION  result, shared by all requesters.
- `Rsp_Error`  out  1  watchdog expiry flag; constant 0 without the macro.
- `Fpu_A`, `Fpu_B`  out  PRECISION  registered operands to the FPU.
- `Fpu_Op`  out  2  registered opcode to the FPU `Operation` input.
- `Fpu_Start`  out  1  drives the FPU `Reset` input; high = hold/restart.
- `Fpu_Result`  in  PRECISION  FPU `Result`.
- `Fpu_Done`  in  1  FPU `Done`.

## Operation
- FSM states are IDLE, LAUNCH, WAIT and RESPOND.
- **IDLE:**
  - When any `Req_Valid` bit is high, the arbiter grants requester g.
  - g is the first valid index searching upward from `last+1`, with wrap-around.
  - `Req_Ready[g]` is asserted combinationally in this cycle only; the handshake completes on this edge.
  - On that edge, `Req_A/B/Op[g]` are captured into the `Fpu_*` registers, `owner<=g`, and the FSM moves to LAUNCH.
- **LAUNCH:**
  - `Fpu_Start=1` for exactly `START_CYCLES` cycles, counted by a start counter.
  - `Fpu_Done` is ignored during LAUNCH; the FPU is held in reset and `Done` may be stale.
  - The FSM then moves to WAIT.
- **WAIT:**
  - `Fpu_Start=0`.
  - On the first edge where `Fpu_Done==1`, `Rsp_Result<=Fpu_Result` and the FSM moves to RESPOND.
- **RESPOND:**
  - `Rsp_Valid[owner]=1`; `Rsp_Result` is held stable.
  - The state is held until `Rsp_Ready[owner]` is high.
  - On that edge: `last<=owner`, `Rsp_Valid` goes to 0, and the FSM moves to IDLE.
- Rules common to all states:
  - Requests are never accepted outside IDLE; `Req_Ready` is all-zero in LAUNCH, WAIT and RESPOND.
  - `Fpu_A/B/Op` stay stable from capture until the next grant.
  - `Rsp_Ready` bits of non-owners are ignored.
  - A requester may drop `Req_Valid` before it is granted without side effects.
- Reset values:
  - State = IDLE.
  - `last = NUM_REQ-1`, so requester 0 wins first.
  - All of `Req_Ready`, `Rsp_Valid`, `Rsp_Result`, `Rsp_Error`, `Fpu_A`, `Fpu_B`, `Fpu_Op`, `Fpu_Start` are 0.
- Reset asserted mid-operation aborts the transaction immediately. No response is produced and the transaction is lost.

## Timing
- Handshake at edge T.
- `Fpu_Start` is high in cycles T+1..T+START_CYCLES.
- WAIT begins at T+START_CYCLES+1.
- `Fpu_Done` sampled high at edge D gives `Rsp_Valid` high from the cycle after D.
- Minimum turnaround between the response handshake and the next grant is one IDLE cycle.
- Arbitration is fair: with all requesters continuously valid, each is served once per `NUM_REQ` transactions.

## Configuration
- Macro: `FPU_ARB_TIMEOUT_EN`.
- **Defined:**
  - A WAIT cycle counter runs, cleared on entry to WAIT.
  - If `Fpu_Done` is not seen within `TIMEOUT_CYCLES` WAIT cycles, the FSM moves to RESPOND with `Rsp_Result` = NaN and `Rsp_Error=1`.
  - NaN for PRECISION=32 is 0x7FFFFFFF; for 64 it is sign 0, all-ones exponent and all-ones mantissa.
  - `Rsp_Error` clears on the response handshake.
  - Done and expiry on the same edge: Done wins.
- **Not defined:**
  - No counter logic is compiled.
  - WAIT lasts indefinitely until `Fpu_Done`.
  - `Rsp_Error` is tied to 0.

## Test plan
- Requester 0 mul 0x3FC00000 × 0x3FC00000 (1.5×1.5) -> `Fpu_Start` high exactly 2 cycles, then `Rsp_Valid=01` with `Rsp_Result=0x40100000`, `Rsp_Error=0`.
- Both requesters valid after reset: req0 add 0x40A00000+0x40000000, req1 div 0x42C80000/0x42480000.
  - req0 is served first with 0x40E00000, then req1 with 0x40000000.
  - Repeating the simultaneous pair yields order req0, req1 again.
- `Rsp_Ready` held low 5 cycles in RESPOND -> `Rsp_Valid` and `Rsp_Result` are stable throughout, and `Req_Ready` stays 0 despite a pending req1.
- Stale `Fpu_Done=1` held through LAUNCH -> not sampled; the response carries the new operation's result.
- With `FPU_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`, FPU model never asserts Done -> after 16 WAIT cycles the requester gets `Rsp_Result=0x7FFFFFFF`, `Rsp_Error=1`; the next request proceeds normally.
- `Reset` pulsed low during WAIT -> all outputs 0 asynchronously, FSM in IDLE, no response for the aborted operation, and requester 0 has priority on the next request.
